// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_pkg;

  localparam int unsigned MIN_BITS = 5;
  localparam int unsigned MAX_BITS = 9;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  typedef enum logic [1:0] {
    ParNone    = 2'd0,
    ParEven    = 2'd1,
    ParOdd     = 2'd2,
    ParNoneAlt = 2'd3
  } par_e;

  function automatic logic [3:0] clamp_bits(input logic [3:0] bits);
    logic [3:0] res;
    res = bits;
    if (bits < 4'(MIN_BITS)) res = 4'(MIN_BITS);
    if (bits > 4'(MAX_BITS)) res = 4'(MAX_BITS);
    return res;
  endfunction

endpackage

// File: rtl/uart_frac_div.sv
// Fractional bit-period timer: each bit lasts I+c clocks where {c,acc} = acc + F.
module uart_frac_div #(
  parameter int unsigned IW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic          advance,
  input  logic          active,
  input  logic [IW-1:0] i_int,
  input  logic [7:0]    f_frac,
  output logic          bit_end
);

  logic [7:0]  acc_q;
  logic [IW:0] cnt_q;
  logic [8:0]  sum;
  logic [IW:0] base;
  logic [IW:0] len_m1;

  always_comb begin
    // A restart begins a fresh frame sequence, so the accumulator starts from zero.
    sum    = {1'b0, (restart ? 8'd0 : acc_q)} + {1'b0, f_frac};
    base   = (i_int == '0) ? {1'b1, {IW{1'b0}}} : {1'b0, i_int};
    len_m1 = base + {{IW{1'b0}}, sum[8]} - {{IW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (restart || advance) begin
      acc_q <= sum[7:0];
      cnt_q <= len_m1;
    end else if (active && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign bit_end = active && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with push FIFO, run-time frame format and 16.8 fractional divider.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DIV_W = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [3:0]                 cfg_bits,
  input  logic [1:0]                 cfg_par,
  input  logic                       cfg_stop,
  input  logic [DIV_W-1:0]           div,
  input  logic                       push,
  input  logic [8:0]                 din,
  input  logic                       ovf_clr,
  output logic                       tx,
  output logic                       busy,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf
);
  import uart_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned IW = DIV_W - 8;

  // FIFO storage and bookkeeping
  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic          ovf_q;
  logic          do_push;

  // Frame state
  state_e        state_q;
  logic          tx_q, busy_q;
  logic [8:0]    shift_q;
  logic [3:0]    nbits_q, sent_q;
  par_e          par_q;
  logic          stop2_q, stop_second_q, parity_q;
  logic [DIV_W-1:0] div_q;

  logic          pop, restart, advance, last_stop, bit_end, active;
  logic [DIV_W-1:0] div_sel;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign ovf     = ovf_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign do_push = push && !full;

  always_comb begin
    active    = (state_q != StIdle);
    last_stop = (state_q == StStop) && bit_end && (!stop2_q || stop_second_q);
    pop       = en && !empty && ((state_q == StIdle) || last_stop);
    restart   = pop && (state_q == StIdle);
    advance   = bit_end && !(last_stop && !pop);
    // A back-to-back pop must time its start bit with the newly latched divisor.
    div_sel   = pop ? div : div_q;
  end

  uart_frac_div #(
    .IW (IW)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .advance (advance),
    .active  (active),
    .i_int   (div_sel[DIV_W-1:8]),
    .f_frac  (div_sel[7:0]),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      if (do_push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (!do_push && pop) begin
        level_q <= level_q - 1'b1;
      end
      // Overflow is judged on the pre-edge full flag, so a same-cycle pop does not rescue it.
      if (ovf_clr) begin
        ovf_q <= 1'b0;
      end else if (push && full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      shift_q       <= '0;
      nbits_q       <= 4'(MIN_BITS);
      sent_q        <= '0;
      par_q         <= ParNone;
      stop2_q       <= 1'b0;
      stop_second_q <= 1'b0;
      parity_q      <= 1'b0;
      div_q         <= '0;
    end else if (pop) begin
      state_q       <= StStart;
      tx_q          <= 1'b0;
      busy_q        <= 1'b1;
      shift_q       <= mem_q[rptr_q];
      nbits_q       <= clamp_bits(cfg_bits);
      par_q         <= par_e'(cfg_par);
      stop2_q       <= cfg_stop;
      stop_second_q <= 1'b0;
      parity_q      <= 1'b0;
      div_q         <= div;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
        StStart: begin
          if (bit_end) begin
            state_q  <= StData;
            tx_q     <= shift_q[0];
            parity_q <= shift_q[0];
            shift_q  <= shift_q >> 1;
            sent_q   <= 4'd1;
          end
        end
        StData: begin
          if (bit_end) begin
            if (sent_q == nbits_q) begin
              if ((par_q == ParEven) || (par_q == ParOdd)) begin
                state_q <= StParity;
                tx_q    <= parity_q ^ (par_q == ParOdd);
              end else begin
                state_q       <= StStop;
                tx_q          <= 1'b1;
                stop_second_q <= 1'b0;
              end
            end else begin
              tx_q     <= shift_q[0];
              parity_q <= parity_q ^ shift_q[0];
              shift_q  <= shift_q >> 1;
              sent_q   <= sent_q + 4'd1;
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            state_q       <= StStop;
            tx_q          <= 1'b1;
            stop_second_q <= 1'b0;
          end
        end
        StStop: begin
          if (bit_end) begin
            if (!last_stop) begin
              stop_second_q <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: stimulus queues expected frames; negedge monitors check tx and busy.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  cfg_bits;
  logic [1:0]  cfg_par;
  logic        cfg_stop;
  logic [23:0] div;
  logic        push;
  logic [8:0]  din;
  logic        ovf_clr;
  logic        tx, busy, full, empty, ovf;
  logic [3:0]  level;

  uart_tx_fifo #(
    .DEPTH (8),
    .DIV_W (24)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .en       (en),
    .cfg_bits (cfg_bits),
    .cfg_par  (cfg_par),
    .cfg_stop (cfg_stop),
    .div      (div),
    .push     (push),
    .din      (din),
    .ovf_clr  (ovf_clr),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]       n;
    logic [15:0]      lvl;
    logic [15:0][3:0] dur;
    logic             b2b;
    logic             last;
  } frame_t;

  frame_t exp_q[$];
  int     blen_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     mon_off = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bit(s); spec bit timing.
  function automatic frame_t mk_frame(input logic [8:0] d, input int bits, input int par,
                                      input bit stop2, input logic [23:0] dv,
                                      input bit b2b, input bit last);
    frame_t f;
    int nb, k, ii, fr, acc, s;
    logic p;
    f   = '0;
    nb  = (bits < 5) ? 5 : ((bits > 9) ? 9 : bits);
    k   = 0;
    p   = 1'b0;
    ii  = int'(dv[23:8]);
    fr  = int'(dv[7:0]);
    acc = 0;
    f.lvl[k] = 1'b0; k++;
    for (int b = 0; b < nb; b++) begin
      f.lvl[k] = d[b];
      p = p ^ d[b];
      k++;
    end
    if (par == 1 || par == 2) begin
      f.lvl[k] = (par == 2) ? ~p : p;
      k++;
    end
    f.lvl[k] = 1'b1; k++;
    if (stop2) begin
      f.lvl[k] = 1'b1; k++;
    end
    for (int j = 0; j < k; j++) begin
      s = acc + fr;
      f.dur[j] = 4'(ii + s / 256);
      acc = s % 256;
    end
    f.n    = 5'(k);
    f.b2b  = b2b;
    f.last = last;
    return f;
  endfunction

  // tx monitor
  frame_t cur;
  bit     in_frame = 1'b0, pend_fall = 1'b0, lost = 1'b0, bad = 1'b0;
  logic   bad_val;
  int     bit_idx = 0, cyc = 0, gap = 0;

  always @(negedge clk) begin
    if (mon_off || !rst_n) begin
      in_frame = 1'b0; pend_fall = 1'b0; lost = 1'b0; gap = 0;
    end else begin
      if (pend_fall) begin
        check("busy_fall", int'(busy), 0);
        pend_fall = 1'b0;
      end
      if (lost) begin
        if (!busy) lost = 1'b0;
      end else if (!in_frame) begin
        if (busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
            lost = 1'b1;
          end else begin
            cur = exp_q.pop_front();
            if (cur.b2b) check("b2b_gap", gap, 0);
            in_frame = 1'b1; bit_idx = 0; cyc = 0; bad = 1'b0;
          end
        end else begin
          gap++;
        end
      end
      if (in_frame) begin
        if (!bad) bad_val = cur.lvl[bit_idx];
        if (tx !== cur.lvl[bit_idx]) begin
          bad = 1'b1;
          bad_val = tx;
        end
        cyc++;
        if (cyc == int'(cur.dur[bit_idx])) begin
          check($sformatf("tx_bit%0d", bit_idx), int'(bad_val), int'(cur.lvl[bit_idx]));
          bit_idx++; cyc = 0; bad = 1'b0;
          if (bit_idx == int'(cur.n)) begin
            in_frame = 1'b0;
            gap = 0;
            if (cur.last) pend_fall = 1'b1;
          end
        end
      end
    end
  end

  // busy run-length monitor
  int brun = 0;
  always @(negedge clk) begin
    if (mon_off || !rst_n) begin
      brun = 0;
    end else if (busy) begin
      brun++;
    end else if (brun > 0) begin
      if (blen_q.size() == 0) check("unexpected_busy_run", brun, 0);
      else check("busy_len", brun, blen_q.pop_front());
      brun = 0;
    end
  end

  task automatic do_push(input logic [8:0] d);
    @(posedge clk); #1;
    push = 1'b1; din = d;
    @(posedge clk); #1;
    push = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(busy == 1'b0 && exp_q.size() == 0 && !in_frame && !pend_fall &&
             blen_q.size() == 0 && brun == 0) && n < 600) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_timeout"}, int'(n >= 600), 0);
  endtask

  task automatic set_cfg(input int bits, input int par, input bit stop2, input logic [23:0] dv);
    cfg_bits = 4'(bits); cfg_par = 2'(par); cfg_stop = stop2; div = dv;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; en = 1'b0; push = 1'b0; din = '0; ovf_clr = 1'b0;
    set_cfg(8, 0, 1'b0, 24'h000200);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_full", int'(full), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_level", int'(level), 0);
    check("rst_ovf", int'(ovf), 0);
    #2 rst_n = 1'b1;
    en = 1'b1;

    // 1: 8N1, 2 clk per bit
    exp_q.push_back(mk_frame(9'h030, 8, 0, 1'b0, 24'h000200, 1'b0, 1'b1));
    blen_q.push_back(20);
    do_push(9'h030);
    wait_idle("t1");

    // 2: fractional 2.5 clk bits
    set_cfg(8, 0, 1'b0, 24'h000280);
    exp_q.push_back(mk_frame(9'h055, 8, 0, 1'b0, 24'h000280, 1'b0, 1'b1));
    blen_q.push_back(25);
    do_push(9'h055);
    wait_idle("t2");

    // 3: 7E2 then 7O1
    set_cfg(7, 1, 1'b1, 24'h000100);
    exp_q.push_back(mk_frame(9'h041, 7, 1, 1'b1, 24'h000100, 1'b0, 1'b1));
    blen_q.push_back(11);
    do_push(9'h041);
    wait_idle("t3a");
    set_cfg(7, 2, 1'b0, 24'h000100);
    exp_q.push_back(mk_frame(9'h041, 7, 2, 1'b0, 24'h000100, 1'b0, 1'b1));
    blen_q.push_back(10);
    do_push(9'h041);
    wait_idle("t3b");

    // 4: overflow with en low, then back-to-back drain
    set_cfg(8, 0, 1'b0, 24'h000100);
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk_frame(9'(8'h10 + i), 8, 0, 1'b0, 24'h000100, i > 0, i == 7));
    end
    blen_q.push_back(80);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      push = 1'b1; din = 9'(8'h10 + i);
      @(posedge clk); #1;
    end
    push = 1'b0;
    check("t4_full", int'(full), 1);
    check("t4_level", int'(level), 8);
    check("t4_ovf", int'(ovf), 1);
    push = 1'b1; din = 9'h1FF; ovf_clr = 1'b1;
    @(posedge clk); #1;
    push = 1'b0; ovf_clr = 1'b0;
    check("t4_ovf_clr_prio", int'(ovf), 0);
    check("t4_level_hold", int'(level), 8);
    en = 1'b1;
    wait_idle("t4");
    check("t4_empty", int'(empty), 1);

    // 5: bit-count clamping and mid-frame config change
    set_cfg(12, 0, 1'b0, 24'h000100);
    exp_q.push_back(mk_frame(9'h1A5, 9, 0, 1'b0, 24'h000100, 1'b0, 1'b1));
    blen_q.push_back(11);
    do_push(9'h1A5);
    wait_idle("t5a");
    set_cfg(2, 0, 1'b0, 24'h000100);
    exp_q.push_back(mk_frame(9'h1A5, 5, 0, 1'b0, 24'h000100, 1'b0, 1'b1));
    blen_q.push_back(7);
    do_push(9'h1A5);
    repeat (2) @(posedge clk);
    #1 set_cfg(9, 2, 1'b1, 24'h000300);
    wait_idle("t5b");
    set_cfg(8, 0, 1'b0, 24'h000200);

    // 6: asynchronous reset mid-DATA
    mon_off = 1'b1;
    do_push(9'h000);
    do_push(9'h0FF);
    repeat (6) @(posedge clk);
    #1 check("t6_pre_tx", int'(tx), 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_tx", int'(tx), 1);
    check("t6_busy", int'(busy), 0);
    check("t6_empty", int'(empty), 1);
    check("t6_level", int'(level), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    mon_off = 1'b0;
    exp_q.push_back(mk_frame(9'h05A, 8, 0, 1'b0, 24'h000200, 1'b0, 1'b1));
    blen_q.push_back(20);
    do_push(9'h05A);
    wait_idle("t6");

    check("exp_q_drained", exp_q.size(), 0);
    check("blen_q_drained", blen_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
